// File: rtl/bp_tlb_miss_sequencer.sv
// TLB miss sequencer: accepts up to two misses per cycle, serialises page walks and writes fills or reports faults.
// Optional BP_TLB_MISS_DEDUP_EN drops duplicate pending misses (same-cycle equal tags, or equal to the just-filled tag).
module bp_tlb_miss_sequencer #(
  parameter int unsigned vtag_width_p  = 27,
  parameter int unsigned entry_width_p = 40
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,

  input  logic                     miss0_v_i,
  input  logic                     miss1_v_i,
  input  logic [vtag_width_p-1:0]  miss0_vtag_i,
  input  logic [vtag_width_p-1:0]  miss1_vtag_i,
  output logic                     miss_ready_o,

  output logic                     ptw_v_o,
  output logic [vtag_width_p-1:0]  ptw_vtag_o,
  input  logic                     ptw_ready_i,

  input  logic                     ptw_resp_v_i,
  input  logic                     ptw_fault_i,
  input  logic [entry_width_p-1:0] ptw_entry_i,

  output logic                     tlb_w_v_o,
  output logic [vtag_width_p-1:0]  tlb_vtag_o,
  output logic [entry_width_p-1:0] tlb_entry_o,

  output logic                     fault_v_o,
  output logic [vtag_width_p-1:0]  fault_vtag_o,

  output logic                     busy_o
);

`ifdef BP_TLB_MISS_DEDUP_EN
  localparam bit dedup_lp = 1'b1;
`else
  localparam bit dedup_lp = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FILL  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  state_e                   r_state,      w_state_n;
  logic [vtag_width_p-1:0]  r_active,     w_active_n;
  logic [vtag_width_p-1:0]  r_pend,       w_pend_n;
  logic                     r_pend_v,     w_pend_v_n;
  logic [entry_width_p-1:0] r_entry,      w_entry_n;
  logic                     r_fault_v,    w_fault_v_n;
  logic [vtag_width_p-1:0]  r_fault_vtag, w_fault_vtag_n;

  logic w_ready;
  logic w_accept;
  logic w_dup_miss;
  logic w_dup_fill;

  assign w_ready    = (r_state == ST_IDLE) && !r_pend_v && !flush_i;
  assign w_accept   = w_ready && (miss0_v_i || miss1_v_i);
  assign w_dup_miss = dedup_lp && (miss0_vtag_i == miss1_vtag_i);
  assign w_dup_fill = dedup_lp && (r_pend == r_active);

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state      <= ST_IDLE;
      r_active     <= '0;
      r_pend       <= '0;
      r_pend_v     <= 1'b0;
      r_entry      <= '0;
      r_fault_v    <= 1'b0;
      r_fault_vtag <= '0;
    end else begin
      r_state      <= w_state_n;
      r_active     <= w_active_n;
      r_pend       <= w_pend_n;
      r_pend_v     <= w_pend_v_n;
      r_entry      <= w_entry_n;
      r_fault_v    <= w_fault_v_n;
      r_fault_vtag <= w_fault_vtag_n;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_n      = r_state;
    w_active_n     = r_active;
    w_pend_n       = r_pend;
    w_pend_v_n     = r_pend_v;
    w_entry_n      = r_entry;
    w_fault_v_n    = 1'b0;
    w_fault_vtag_n = r_fault_vtag;

    case (r_state)
      ST_IDLE: begin
        if (flush_i) begin
          w_pend_v_n = 1'b0;
        end else if (w_accept) begin
          w_state_n  = ST_REQ;
          w_active_n = miss0_v_i ? miss0_vtag_i : miss1_vtag_i;
          if (miss0_v_i && miss1_v_i && !w_dup_miss) begin
            w_pend_n   = miss1_vtag_i;
            w_pend_v_n = 1'b1;
          end
        end
      end

      ST_REQ: begin
        if (flush_i) begin
          w_state_n  = ST_IDLE;
          w_pend_v_n = 1'b0;
        end else if (ptw_ready_i) begin
          w_state_n = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (ptw_resp_v_i && flush_i) begin
          w_state_n  = ST_IDLE;
          w_pend_v_n = 1'b0;
        end else if (ptw_resp_v_i && ptw_fault_i) begin
          // Fault reported next cycle; the pending miss may already start its walk then
          w_fault_v_n    = 1'b1;
          w_fault_vtag_n = r_active;
          if (r_pend_v) begin
            w_state_n  = ST_REQ;
            w_active_n = r_pend;
            w_pend_v_n = 1'b0;
          end else begin
            w_state_n = ST_IDLE;
          end
        end else if (ptw_resp_v_i) begin
          w_state_n = ST_FILL;
          w_entry_n = ptw_entry_i;
        end else if (flush_i) begin
          w_state_n  = ST_DRAIN;
          w_pend_v_n = 1'b0;
        end
      end

      ST_FILL: begin
        w_pend_v_n = 1'b0;
        if (flush_i) begin
          w_state_n = ST_IDLE;
        end else if (r_pend_v && !w_dup_fill) begin
          w_state_n  = ST_REQ;
          w_active_n = r_pend;
        end else begin
          w_state_n = ST_IDLE;
        end
      end

      ST_DRAIN: begin
        if (ptw_resp_v_i) begin
          w_state_n = ST_IDLE;
        end
      end

      default: begin
        w_state_n  = ST_IDLE;
        w_pend_v_n = 1'b0;
      end
    endcase
  end

  // Flush masks every side effect in the cycle it is asserted
  assign miss_ready_o = w_ready;
  assign ptw_v_o      = (r_state == ST_REQ) && !flush_i;
  assign ptw_vtag_o   = r_active;
  assign tlb_w_v_o    = (r_state == ST_FILL) && !flush_i;
  assign tlb_vtag_o   = r_active;
  assign tlb_entry_o  = r_entry;
  assign fault_v_o    = r_fault_v && !flush_i;
  assign fault_vtag_o = r_fault_vtag;
  assign busy_o       = (r_state != ST_IDLE) || r_pend_v;

endmodule

// File: tb/tb_bp_tlb_miss_sequencer.sv
// Self-checking bench for bp_tlb_miss_sequencer: directed scenarios plus random traffic against a queue-based model.
// Define BP_TLB_MISS_DEDUP_EN for both bench and RTL to exercise the dedup build.
module tb_bp_tlb_miss_sequencer;
  localparam int unsigned VW = 27;
  localparam int unsigned EW = 40;
`ifdef BP_TLB_MISS_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i, flush_i;
  logic          miss0_v_i, miss1_v_i;
  logic [VW-1:0] miss0_vtag_i, miss1_vtag_i;
  logic          miss_ready_o;
  logic          ptw_v_o, ptw_ready_i;
  logic [VW-1:0] ptw_vtag_o;
  logic          ptw_resp_v_i, ptw_fault_i;
  logic [EW-1:0] ptw_entry_i;
  logic          tlb_w_v_o;
  logic [VW-1:0] tlb_vtag_o;
  logic [EW-1:0] tlb_entry_o;
  logic          fault_v_o;
  logic [VW-1:0] fault_vtag_o;
  logic          busy_o;

  always #5 clk = ~clk;

  bp_tlb_miss_sequencer #(.vtag_width_p(VW), .entry_width_p(EW)) dut (
    .clk_i(clk), .reset_i(reset_i), .flush_i(flush_i),
    .miss0_v_i(miss0_v_i), .miss1_v_i(miss1_v_i),
    .miss0_vtag_i(miss0_vtag_i), .miss1_vtag_i(miss1_vtag_i),
    .miss_ready_o(miss_ready_o),
    .ptw_v_o(ptw_v_o), .ptw_vtag_o(ptw_vtag_o), .ptw_ready_i(ptw_ready_i),
    .ptw_resp_v_i(ptw_resp_v_i), .ptw_fault_i(ptw_fault_i), .ptw_entry_i(ptw_entry_i),
    .tlb_w_v_o(tlb_w_v_o), .tlb_vtag_o(tlb_vtag_o), .tlb_entry_o(tlb_entry_o),
    .fault_v_o(fault_v_o), .fault_vtag_o(fault_vtag_o),
    .busy_o(busy_o)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: work list of tags still to be walked (front is the one in flight)
  logic [VW-1:0] m_q[$];
  bit            m_walk, m_drain, m_fill_v, m_fault_v;
  logic [VW-1:0] m_fill_vtag, m_fault_vtag;
  logic [EW-1:0] m_fill_entry;

  // Page-walker behaviour and DUT event logs
  int            rsp_dly    = 0;
  int            cfg_dly    = -1;
  int            fault_mode = 0;
  logic [VW-1:0] walks_q[$], writes_q[$], faults_q[$];

  function automatic bit model_idle();
    return (m_q.size() == 0) && !m_walk && !m_fill_v && !m_fault_v;
  endfunction

  task automatic clear_logs();
    walks_q.delete();
    writes_q.delete();
    faults_q.delete();
  endtask

  task automatic step(input bit rst, input bit fl, input bit v0, input bit v1,
                      input logic [VW-1:0] t0, input logic [VW-1:0] t1, input bit rdy);
    bit            resp, e_busy, e_ready, e_ptw, e_fill, e_fault, take;
    bit            n_fill, n_fault;
    logic [VW-1:0] vt;
    @(negedge clk);
    reset_i      = rst;
    flush_i      = fl;
    miss0_v_i    = v0;
    miss1_v_i    = v1;
    miss0_vtag_i = t0;
    miss1_vtag_i = t1;
    ptw_ready_i  = rdy;
    resp         = m_walk && (rsp_dly == 0);
    ptw_resp_v_i = resp;
    ptw_fault_i  = (fault_mode == 1) || ((fault_mode == 2) && ($urandom_range(0, 3) == 0));
    ptw_entry_i  = EW'({$urandom, $urandom});
    #1;
    e_busy  = (m_q.size() > 0) || m_walk || m_fill_v;
    e_ready = !e_busy && !fl;
    e_ptw   = (m_q.size() > 0) && !m_walk && !m_fill_v && !fl;
    e_fill  = m_fill_v && !fl;
    e_fault = m_fault_v && !fl;
    check("miss_ready", 64'(miss_ready_o), 64'(e_ready));
    check("busy", 64'(busy_o), 64'(e_busy));
    check("ptw_v", 64'(ptw_v_o), 64'(e_ptw));
    if (e_ptw) check("ptw_vtag", 64'(ptw_vtag_o), 64'(m_q[0]));
    check("tlb_w_v", 64'(tlb_w_v_o), 64'(e_fill));
    if (e_fill) begin
      check("tlb_vtag", 64'(tlb_vtag_o), 64'(m_fill_vtag));
      check("tlb_entry", 64'(tlb_entry_o), 64'(m_fill_entry));
    end
    check("fault_v", 64'(fault_v_o), 64'(e_fault));
    if (e_fault) check("fault_vtag", 64'(fault_vtag_o), 64'(m_fault_vtag));
    if (ptw_v_o && ptw_ready_i) walks_q.push_back(ptw_vtag_o);
    if (tlb_w_v_o) writes_q.push_back(tlb_vtag_o);
    if (fault_v_o) faults_q.push_back(fault_vtag_o);

    take    = e_ready && (v0 || v1);
    n_fill  = 1'b0;
    n_fault = 1'b0;
    if (rst) begin
      m_q.delete();
      m_walk  = 1'b0;
      m_drain = 1'b0;
    end else begin
      if (m_walk && !resp) rsp_dly--;
      if (!fl && m_fill_v && DEDUP && (m_q.size() > 0) && (m_q[0] == m_fill_vtag))
        void'(m_q.pop_front());
      if (resp) begin
        m_walk = 1'b0;
        if (!fl && !m_drain) begin
          vt = m_q.pop_front();
          if (ptw_fault_i) begin
            n_fault      = 1'b1;
            m_fault_vtag = vt;
          end else begin
            n_fill       = 1'b1;
            m_fill_vtag  = vt;
            m_fill_entry = ptw_entry_i;
          end
        end
        m_drain = 1'b0;
      end else if (m_walk && fl) begin
        m_drain = 1'b1;
      end
      if (e_ptw && rdy) begin
        m_walk  = 1'b1;
        rsp_dly = (cfg_dly < 0) ? int'($urandom_range(0, 4)) : cfg_dly;
      end
      if (fl) m_q.delete();
      if (take) begin
        if (v0) begin
          m_q.push_back(t0);
          if (v1 && !(DEDUP && (t0 == t1))) m_q.push_back(t1);
        end else begin
          m_q.push_back(t1);
        end
      end
    end
    m_fill_v  = n_fill;
    m_fault_v = n_fault;
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 100; i++) begin
      if (model_idle()) break;
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    end
    check("idle_timeout", 64'(model_idle()), 64'd1);
  endtask

  initial begin
    reset_i      = 1'b1;
    flush_i      = 1'b0;
    miss0_v_i    = 1'b0;
    miss1_v_i    = 1'b0;
    miss0_vtag_i = '0;
    miss1_vtag_i = '0;
    ptw_ready_i  = 1'b0;
    ptw_resp_v_i = 1'b0;
    ptw_fault_i  = 1'b0;
    ptw_entry_i  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_miss_ready", 64'(miss_ready_o), 64'd1);
    check("rst_ptw_v", 64'(ptw_v_o), 64'd0);
    check("rst_ptw_vtag", 64'(ptw_vtag_o), 64'd0);
    check("rst_tlb_w_v", 64'(tlb_w_v_o), 64'd0);
    check("rst_tlb_vtag", 64'(tlb_vtag_o), 64'd0);
    check("rst_tlb_entry", 64'(tlb_entry_o), 64'd0);
    check("rst_fault_v", 64'(fault_v_o), 64'd0);
    check("rst_fault_vtag", 64'(fault_vtag_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);

    // Single miss, fixed walk latency
    clear_logs();
    cfg_dly = 2;
    step(1'b0, 1'b0, 1'b1, 1'b0, VW'(32'h1234), '0, 1'b1);
    idle_wait();
    check("single_walks", 64'(walks_q.size()), 64'd1);
    if (walks_q.size() > 0) check("single_walk_tag", 64'(walks_q[0]), 64'h1234);
    check("single_writes", 64'(writes_q.size()), 64'd1);
    if (writes_q.size() > 0) check("single_write_tag", 64'(writes_q[0]), 64'h1234);

    // Two slots: ordered walks, further misses held off while busy
    clear_logs();
    cfg_dly = -1;
    step(1'b0, 1'b0, 1'b1, 1'b1, VW'(32'h10), VW'(32'h20), 1'b1);
    for (int i = 0; i < 60 && !model_idle(); i++)
      step(1'b0, 1'b0, 1'b1, 1'b1, VW'(32'h99), VW'(32'h98), 1'b1);
    check("pair_walks", 64'(walks_q.size()), 64'd2);
    check("pair_writes", 64'(writes_q.size()), 64'd2);
    if (writes_q.size() == 2) begin
      check("pair_write0", 64'(writes_q[0]), 64'h10);
      check("pair_write1", 64'(writes_q[1]), 64'h20);
    end

    // Equal tags in both slots
    clear_logs();
    step(1'b0, 1'b0, 1'b1, 1'b1, VW'(32'h55), VW'(32'h55), 1'b1);
    idle_wait();
    check("dup_walks", 64'(walks_q.size()), DEDUP ? 64'd1 : 64'd2);
    check("dup_writes", 64'(writes_q.size()), DEDUP ? 64'd1 : 64'd2);

    // Faulting walk
    clear_logs();
    fault_mode = 1;
    step(1'b0, 1'b0, 1'b1, 1'b0, VW'(32'h77), '0, 1'b1);
    idle_wait();
    fault_mode = 0;
    check("fault_writes", 64'(writes_q.size()), 64'd0);
    check("fault_count", 64'(faults_q.size()), 64'd1);
    if (faults_q.size() > 0) check("fault_tag", 64'(faults_q[0]), 64'h77);

    // Flush while waiting: response drained, pending dropped
    clear_logs();
    cfg_dly = 5;
    step(1'b0, 1'b0, 1'b1, 1'b1, VW'(32'h10), VW'(32'h20), 1'b1);
    for (int i = 0; i < 10 && !m_walk; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    idle_wait();
    check("drain_walks", 64'(walks_q.size()), 64'd1);
    check("drain_writes", 64'(writes_q.size()), 64'd0);

    // Walker stalls for five cycles
    clear_logs();
    cfg_dly = 1;
    step(1'b0, 1'b0, 1'b1, 1'b0, VW'(32'h3AB), '0, 1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    idle_wait();
    check("stall_walks", 64'(walks_q.size()), 64'd1);

    // Reset mid-walk drops the walk
    clear_logs();
    cfg_dly = 4;
    step(1'b0, 1'b0, 1'b1, 1'b1, VW'(32'h40), VW'(32'h41), 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    check("rst_mid_walks", 64'(walks_q.size()), 64'd1);
    check("rst_mid_idle", 64'(model_idle()), 64'd1);

    // Random traffic
    cfg_dly    = -1;
    fault_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      logic [VW-1:0] t0, t1;
      t0 = ($urandom_range(0, 1) == 0) ? VW'($urandom_range(0, 3)) : VW'($urandom);
      t1 = ($urandom_range(0, 1) == 0) ? t0 : VW'($urandom_range(0, 3));
      step($urandom_range(0, 299) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           t0, t1, $urandom_range(0, 3) != 0);
    end
    fault_mode = 0;
    idle_wait();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bp_tlb_miss_sequencer.md
BP_TLB_MISS_SEQUENCER -- requirements
Module: bp_tlb_miss_sequencer

Interface
REQ-001 SHALL have parameter vtag_width_p, default 27, virtual tag width.
REQ-002 SHALL have parameter entry_width_p, default 40, TLB leaf entry width.
REQ-003 SHALL have ports clk_i and reset_i: one clock; reset is synchronous and active-high.
REQ-004 SHALL have flush_i  in  1  invalidate all outstanding and pending misses.
REQ-005 SHALL have miss0_v_i, miss1_v_i  in  1 each  TLB miss from issue slot 0 / slot 1.
REQ-006 SHALL have miss0_vtag_i, miss1_vtag_i  in  vtag_width_p each  missing vtags.
REQ-007 SHALL have miss_ready_o  out  1  misses accepted this cycle.
REQ-008 SHALL have ptw_v_o  out  1, ptw_vtag_o  out  vtag_width_p, ptw_ready_i  in  1  page-walk request valid/ready.
REQ-009 SHALL have ptw_resp_v_i  in  1, ptw_fault_i  in  1, ptw_entry_i  in  entry_width_p  walk response (no backpressure).
REQ-010 SHALL have tlb_w_v_o  out  1, tlb_vtag_o  out  vtag_width_p, tlb_entry_o  out  entry_width_p  single TLB fill write port.
REQ-011 SHALL have fault_v_o  out  1, fault_vtag_o  out  vtag_width_p  page-fault report.
REQ-012 SHALL have busy_o  out  1  high whenever state is not IDLE or pending buffer valid.

Function
REQ-013 SHALL implement states IDLE, REQ, WAIT, FILL, DRAIN.
REQ-014 miss_ready_o SHALL be 1 only in IDLE with pending buffer empty and flush_i low.
REQ-015 On accepted miss, slot 0 SHALL have fixed priority: its vtag goes to active register, state IDLE->REQ next cycle.
REQ-016 If both slots miss in the same accepted cycle, slot 1 vtag SHALL be latched into one-entry pending buffer.
REQ-017 In REQ, ptw_v_o=1 with ptw_vtag_o=active vtag; on ptw_ready_i=1 -> WAIT; ptw_vtag_o stable while stalled.
REQ-018 In WAIT, on ptw_resp_v_i with ptw_fault_i=0 -> FILL, entry captured; with ptw_fault_i=1 -> fault_v_o=1 next cycle (one cycle), fault_vtag_o=active vtag, no TLB write.
REQ-019 In FILL, tlb_w_v_o SHALL be 1 for exactly one cycle with captured vtag/entry, then next state.
REQ-020 After FILL or fault: if pending valid, pending moves to active and state -> REQ (ptw_v_o one cycle after tlb_w_v_o); else -> IDLE.
REQ-021 Latency: miss accepted cycle N -> ptw_v_o at N+1; response at cycle M -> tlb_w_v_o at M+1.
REQ-022 flush_i in IDLE/REQ/FILL SHALL clear pending and go IDLE next cycle, suppressing tlb_w_v_o and fault_v_o that cycle.
REQ-023 flush_i in WAIT SHALL clear pending and go DRAIN; DRAIN discards the next response (no write, no fault) then -> IDLE.
REQ-024 flush_i coincident with ptw_resp_v_i in WAIT SHALL discard that response and go IDLE.
REQ-025 At most one walk SHALL be outstanding at any time.

Reset
REQ-026 Reset SHALL force IDLE, pending invalid, and all outputs 0 except miss_ready_o=1.
REQ-027 Reset asserted mid-walk SHALL drop the walk; the PTW is reset in the same cycle, no DRAIN.

Configuration
REQ-028 Macro BP_TLB_MISS_DEDUP_EN, when defined: same-cycle misses with equal vtags SHALL not fill pending; pending whose vtag equals the just-filled vtag SHALL be discarded after FILL (-> IDLE).
REQ-029 Without BP_TLB_MISS_DEDUP_EN: every accepted slot-1 miss SHALL be walked even if tags match.

Verification
REQ-030 Single miss0 vtag 0x1234, ptw_ready_i=1, response after 3 cycles no fault -> ptw_v_o N+1, one tlb_w_v_o vtag 0x1234, back to IDLE.
REQ-031 Both slots miss, 0x10 and 0x20 -> walks 0x10 then 0x20, two writes in that order, miss_ready_o low throughout.
REQ-032 Both slots miss 0x55, DEDUP_EN defined -> one walk, one write; undefined -> two walks, two writes.
REQ-033 Response with ptw_fault_i=1 for 0x77 -> fault_v_o one cycle, fault_vtag_o 0x77, tlb_w_v_o never asserted.
REQ-034 flush_i in WAIT, pending 0x20 -> DRAIN, following response discarded, no write, 0x20 never walked, IDLE.
REQ-035 ptw_ready_i held 0 for 5 cycles in REQ -> ptw_v_o and ptw_vtag_o stable all 5 cycles.
